// File: rtl/bt_uart_pkg.sv
// Shared types and helpers for the parametrised Bluetooth-link UART receiver.
package bt_uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PAR       = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_t;

  // Rounded clk-per-tick divider.
  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Free-running oversample tick generator: one-clk tick every DIV clks, clr restarts the phase.
module uart_tick_gen #(
  parameter int unsigned DIV = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(DIV);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tick_gen: DIV must be >= 2");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_W'(DIV - 1));
    cnt_d = (clr || tick) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bt_uart_rx.sv
// Parametrised oversampling UART receiver with LED latch and pause toggle.
// Optional macro BT_UART_RX_MAJORITY_EN: 3-sample majority vote per bit decision.
module bt_uart_rx
  import bt_uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PAUSE_CODE = 8'h31
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic [DATA_BITS-1:0] leds,
  output logic                 pausa
);

  localparam int unsigned DIV       = baud_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam parity_t     PAR_MODE  = parity_t'(PARITY[1:0]);
  localparam int unsigned TCNT_W    = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_LAST  = OVERSAMPLE - 1;
`ifdef BT_UART_RX_MAJORITY_EN
  localparam int unsigned START_LAST = OVERSAMPLE / 2;
`else
  localparam int unsigned START_LAST = OVERSAMPLE / 2 - 1;
`endif

  if (DIV < 2) begin : g_bad_div
    $error("bt_uart_rx: CLK_HZ/(BAUD*OVERSAMPLE) must round to >= 2");
  end
  if (OVERSAMPLE < 4 || OVERSAMPLE % 2 != 0) begin : g_bad_os
    $error("bt_uart_rx: OVERSAMPLE must be even and >= 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_fmt
    $error("bt_uart_rx: unsupported frame format");
  end

  logic rx_meta_q, rx_sync_q, rx_prev_q;
  logic tick, tick_clr, at_last, bit_s, stop_bad;

  rx_state_t            state_q, state_d;
  logic [TCNT_W-1:0]    tcnt_q, tcnt_d;
  logic [3:0]           bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, data_q, data_d, leds_q, leds_d;
  logic                 par_err_q, par_err_d, stop_bad_q, stop_bad_d;
  logic                 pausa_q, pausa_d, valid_q, valid_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;

  uart_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (tick_clr),
    .tick  (tick)
  );

`ifdef BT_UART_RX_MAJORITY_EN
  // hist_q[1]/hist_q[0] hold the centre-1/centre samples when the centre+1 tick arrives.
  logic [1:0] hist_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    hist_q <= '1;
    else if (tick) hist_q <= {hist_q[0], rx_sync_q};
  end
  assign bit_s = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_sync_q) | (hist_q[0] & rx_sync_q);
`else
  assign bit_s = rx_sync_q;
`endif

  assign at_last  = tick && (tcnt_q == ((state_q == START) ? TCNT_W'(START_LAST)
                                                           : TCNT_W'(BIT_LAST)));
  assign stop_bad = stop_bad_q | ~bit_s;

  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    bcnt_d     = bcnt_q;
    sh_d       = sh_q;
    par_err_d  = par_err_q;
    stop_bad_d = stop_bad_q;
    data_d     = data_q;
    leds_d     = leds_q;
    pausa_d    = pausa_q;
    valid_d    = 1'b0;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;
    tick_clr   = 1'b0;

    if (state_q == IDLE)  tcnt_d = '0;
    else if (tick)        tcnt_d = at_last ? '0 : tcnt_q + TCNT_W'(1);

    case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          state_d  = START;
          tick_clr = 1'b1;
        end
      end
      START: begin
        if (at_last) begin
          if (!bit_s) begin
            state_d    = DATA;
            bcnt_d     = '0;
            par_err_d  = 1'b0;
            stop_bad_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (at_last) begin
          sh_d = {bit_s, sh_q[DATA_BITS-1:1]};
          if (bcnt_q == 4'(DATA_BITS - 1)) begin
            bcnt_d  = '0;
            state_d = (PAR_MODE == PAR_NONE) ? STOP : PAR;
          end else begin
            bcnt_d = bcnt_q + 4'd1;
          end
        end
      end
      PAR: begin
        if (at_last) begin
          par_err_d = (^sh_q) ^ bit_s ^ (PAR_MODE == PAR_ODD);
          state_d   = STOP;
        end
      end
      STOP: begin
        if (at_last) begin
          if (bcnt_q == 4'(STOP_BITS - 1)) begin
            bcnt_d = '0;
            if (stop_bad) begin
              ferr_d  = 1'b1;
              state_d = WAIT_HIGH;
            end else begin
              valid_d = 1'b1;
              data_d  = sh_q;
              state_d = IDLE;
              if (par_err_q) begin
                perr_d = 1'b1;
              end else begin
                leds_d = sh_q;
                if (sh_q == DATA_BITS'(PAUSE_CODE)) pausa_d = ~pausa_q;
              end
            end
          end else begin
            stop_bad_d = stop_bad;
            bcnt_d     = bcnt_q + 4'd1;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_sync_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= IDLE;
      tcnt_q     <= '0;
      bcnt_q     <= '0;
      sh_q       <= '0;
      par_err_q  <= 1'b0;
      stop_bad_q <= 1'b0;
      data_q     <= '0;
      leds_q     <= '0;
      pausa_q    <= 1'b0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      bcnt_q     <= bcnt_d;
      sh_q       <= sh_d;
      par_err_q  <= par_err_d;
      stop_bad_q <= stop_bad_d;
      data_q     <= data_d;
      leds_q     <= leds_d;
      pausa_q    <= pausa_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign data       = data_q;
  assign leds       = leds_q;
  assign pausa      = pausa_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

endmodule

// File: doc/bt_uart_rx.md
# bt_uart_rx

- Parametrised UART receiver; replaces the fixed 8N1/9600 Bluetooth receiver on the HC-06/HM-10 link.
- Oversampled, glitch-rejecting start detect; configurable data width, parity and stop bits.
- Reports every frame with a one-cycle valid strobe plus error flags; keeps the latched LED byte and the pause toggle for the VGA pipeline.

## Interface
Parameters:
- CLK_HZ, 50_000_000, system clock frequency
- BAUD, 9600, line rate
- OVERSAMPLE, 16, ticks per bit; even, ≥4
- DATA_BITS, 8, payload bits, 5..9, LSB first
- PARITY, 0, 0 none / 1 even / 2 odd
- STOP_BITS, 1, 1 or 2
- PAUSE_CODE, 8'h31, byte that toggles pausa (low DATA_BITS compared)

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-low reset
- rx  in  1  serial line from module DO, idle high, asynchronous
- data  out  DATA_BITS  last received payload, valid with valid
- valid  out  1  one-cycle strobe per accepted frame
- parity_err  out  1  one-cycle strobe, coincident with valid
- frame_err  out  1  one-cycle strobe, stop bit sampled low
- leds  out  DATA_BITS  payload of last error-free frame
- pausa  out  1  toggles on each error-free PAUSE_CODE frame

## Operation
- rx passes a 2-FF synchroniser; both flops reset to 1.
- Tick generator: DIV = round(CLK_HZ/(BAUD*OVERSAMPLE)), DIV ≥ 2, else elaboration error.
  - Counter width is $clog2(DIV).
  - tick pulses one clk every DIV clks, free-running.
- FSM states: IDLE, START, DATA, PAR, STOP, WAIT_HIGH.
- IDLE:
  - A synced rx high→low edge → START.
  - The tick phase counter clears on entry to START.
- START: after OVERSAMPLE/2 ticks, sample rx.
  - Low → DATA.
  - High → IDLE (glitch rejected; no flags).
- DATA:
  - Sample every OVERSAMPLE ticks.
  - Shift right into shift register: MSB in, LSB first.
  - After DATA_BITS samples → PAR if PARITY≠0, else STOP.
- PAR: one sample. Compute parity error:
  - even: XOR(data, bit) ≠ 0
  - odd: XOR(data, bit) ≠ 1
- STOP: sample STOP_BITS times.
  - Any low sample → frame_err, go to WAIT_HIGH; valid stays low; data, leds and pausa are unchanged.
  - All high, PARITY=0 or no parity error:
    - Pulse valid; update data and leds.
    - If payload == PAUSE_CODE, toggle pausa.
    - Go to IDLE.
  - All high, parity error:
    - Pulse valid and parity_err; update data only.
    - leds and pausa are unchanged.
    - Go to IDLE.
- WAIT_HIGH (break or line low): stay until synced rx is high, then IDLE. No new start is accepted while here.
- Reset values: all outputs 0, FSM in IDLE. This holds even if reset is asserted mid-frame.

## Timing
- Start edge to first data sample: OVERSAMPLE/2 + OVERSAMPLE ticks (bit centre), ±1 tick. Add 2 clk of synchroniser delay.
- valid, parity_err and frame_err are asserted the clk after the last stop sample. Width is exactly 1 clk.
- data and leds are registered in the same clk as valid.
- pausa toggles in the same clk as valid.
- Back-to-back frames:
  - A start edge is accepted from the clk after the last stop sample.
  - In 2-stop mode, the second stop bit is also sampled before IDLE.
- Tolerated baud mismatch: ±3% at OVERSAMPLE=16.

## Configuration
- Macro: BT_UART_RX_MAJORITY_EN.
- Defined: every bit decision (start confirm, data, parity, stop) is the majority of 3 samples. The samples are taken at centre-1, centre and centre+1 ticks, and the decision is registered at centre+1. valid therefore shifts 1 tick later.
- Undefined: single sample at centre tick.

## Structure
- Package bt_uart_pkg holds:
  - parity_t enum (PAR_NONE, PAR_EVEN, PAR_ODD)
  - rx_state_t enum for the six FSM states
  - function baud_div(clk_hz, baud, os)
- Sub-module uart_tick_gen (params DIV; ports clk, reset, clr, tick) is instantiated once.
- FSM, shift register and output logic stay in bt_uart_rx.

## Test plan
All cases use CLK_HZ=50e6, BAUD=115200, OVERSAMPLE=16, so DIV=27 and bit = 432 clk.
- 8N1, send 0x31 twice:
  - Two valid pulses, data=0x31, leds=0x31.
  - pausa goes 0→1→0.
  - No error strobes.
- 8E1, send 0xA5 with correct parity bit 0:
  - valid with data=0xA5, leds=0xA5.
- 8E1, send 0x31 with parity bit 0 (wrong):
  - valid and parity_err together, data=0x31.
  - leds unchanged and pausa unchanged.
- Hold rx low for 20 bit times:
  - One frame_err, no valid.
  - FSM stays in WAIT_HIGH until rx rises; then 0x55 is received correctly.
- 200 ns low glitch on idle rx: no strobes, FSM returns to IDLE.
  - With BT_UART_RX_MAJORITY_EN, a 1-tick glitch at a data-bit centre in 0x00 still yields 0x00.
- Assert reset mid-DATA of 0x31:
  - All outputs 0 immediately.
  - The next full 0x42 frame after release is received correctly.
